// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg: shared register-file geometry for the writeback arbiter.
package regfile_wr_arbiter_pkg;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
    localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/decoder.sv
// decoder: enable-gated binary to one-hot decode.
module decoder #(
    parameter int IN_W = 5
) (
    input  logic [IN_W-1:0]      i_sel,
    input  logic                 i_en,
    output logic [2**IN_W-1:0]   o_dec
);
    always_comb o_dec = i_en ? (2**IN_W)'(1) << i_sel : '0;
endmodule

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin search of valid starting at ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] w_cand;
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = (int'(i_ptr) + k >= N) ? IDX_W'(int'(i_ptr) + k - N) : IDX_W'(int'(i_ptr) + k);
            if (!o_any && i_valid[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                o_any           = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin share of the regfile write port plus a busy scoreboard.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [NUM_REGS-1:0]       wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [NUM_REGS-1:0]       busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_REGS-1:0] r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [NUM_REGS-1:0] r_busy;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [NUM_REGS-1:0] w_wr_dec;
    logic [NUM_REGS-1:0] w_rsv_dec;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grants are suppressed while reset is held so nothing is accepted and then discarded.
    assign req_ready = reset ? w_grant : '0;
    assign w_xfer    = reset && w_any;
    assign w_addr    = req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_data    = req_data[w_idx*DATA_W +: DATA_W];

    // r0 is hardwired zero: its writes are accepted but never enabled or reserved.
    decoder #(.IN_W(ADDR_W)) u_wr_dec (
        .i_sel (w_addr),
        .i_en  (w_xfer && w_addr != ADDR_W'(REG_ZERO)),
        .o_dec (w_wr_dec)
    );

    decoder #(.IN_W(ADDR_W)) u_rsv_dec (
        .i_sel (rsv_addr),
        .i_en  (rsv_valid && rsv_addr != ADDR_W'(REG_ZERO)),
        .o_dec (w_rsv_dec)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
        end else begin
            r_wr_en <= w_wr_dec;
            r_busy  <= (r_busy & ~w_wr_dec) | w_rsv_dec;
            if (w_xfer) begin
                r_ptr     <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed checks of arbitration, write stage, scoreboard and async reset.
module tb_regfile_wr_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [31:0] wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    int vectors = 0;
    int errors  = 0;

    regfile_wr_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        req_valid = 3'b111;
        req_addr  = {5'd5, 5'd4, 5'd3};
        req_data  = {32'hA2, 32'hA1, 32'hA0};
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        tick();
        tick();
        vectors++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
        vectors++; if (wr_en !== 32'h0) begin errors++; $display("FAIL rst_wr_en got=%h exp=0", wr_en); end
        vectors++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy got=%h exp=0", busy); end
        vectors++; if (wr_addr !== 5'd0 || wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_addr_data got=%0d/%h exp=0/0", wr_addr, wr_data); end
        rsv_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rel_ready got=%b exp=001", req_ready); end
    endtask

    task automatic test_fairness;
        logic [2:0]  exp_r;
        logic [31:0] exp_en;
        for (int c = 0; c < 6; c++) begin
            exp_r  = 3'b001 << (c % 3);
            exp_en = 32'h8 << (c % 3);
            vectors++; if (req_ready !== exp_r) begin errors++; $display("FAIL fair_ready[%0d] got=%b exp=%b", c, req_ready, exp_r); end
            tick();
            vectors++; if (wr_en !== exp_en) begin errors++; $display("FAIL fair_wr_en[%0d] got=%h exp=%h", c, wr_en, exp_en); end
            vectors++; if (wr_data !== 32'hA0 + 32'(c % 3)) begin errors++; $display("FAIL fair_wr_data[%0d] got=%h exp=%h", c, wr_data, 32'hA0 + 32'(c % 3)); end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_single_writer;
        req_valid       = 3'b010;
        req_addr[5 +: 5]  = 5'd7;
        req_data[32 +: 32] = 32'hDEAD_BEEF;
        #1;
        vectors++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
        tick();
        req_valid = 3'b000;
        vectors++; if (wr_en !== 32'h80) begin errors++; $display("FAIL single_wr_en got=%h exp=00000080", wr_en); end
        vectors++; if (wr_addr !== 5'd7) begin errors++; $display("FAIL single_wr_addr got=%0d exp=7", wr_addr); end
        vectors++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wr_data got=%h exp=deadbeef", wr_data); end
        tick();
        vectors++; if (wr_en !== 32'h0) begin errors++; $display("FAIL idle_wr_en got=%h exp=0", wr_en); end
        vectors++; if (wr_addr !== 5'd7 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_hold got=%0d/%h exp=7/deadbeef", wr_addr, wr_data); end
    endtask

    task automatic test_r0_write;
        req_valid         = 3'b001;
        req_addr[0 +: 5]  = 5'd0;
        req_data[0 +: 32] = 32'h1234;
        #1;
        vectors++; if (req_ready !== 3'b001) begin errors++; $display("FAIL r0_ready got=%b exp=001", req_ready); end
        tick();
        req_valid = 3'b000;
        vectors++; if (wr_en !== 32'h0) begin errors++; $display("FAIL r0_wr_en got=%h exp=0", wr_en); end
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL r0_busy got=%b exp=0", busy[0]); end
        vectors++; if (wr_data !== 32'h1234) begin errors++; $display("FAIL r0_wr_data got=%h exp=1234", wr_data); end
    endtask

    task automatic test_scoreboard;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        tick();
        rsv_valid = 1'b0;
        vectors++; if (busy !== 32'h200) begin errors++; $display("FAIL sb_set got=%h exp=00000200", busy); end
        tick();
        req_valid          = 3'b100;
        req_addr[10 +: 5]  = 5'd9;
        req_data[64 +: 32] = 32'h99;
        #1;
        vectors++; if (req_ready !== 3'b100) begin errors++; $display("FAIL sb_ready got=%b exp=100", req_ready); end
        vectors++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sb_hold got=%b exp=1", busy[9]); end
        tick();
        req_valid = 3'b000;
        vectors++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_clear got=%h exp=0", busy); end
        vectors++; if (wr_en !== 32'h200) begin errors++; $display("FAIL sb_wr_en got=%h exp=00000200", wr_en); end
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        req_valid = 3'b100;
        #1;
        vectors++; if (req_ready !== 3'b100) begin errors++; $display("FAIL sb_same_ready got=%b exp=100", req_ready); end
        tick();
        req_valid = 3'b000;
        vectors++; if (busy !== 32'h200) begin errors++; $display("FAIL sb_same_edge got=%h exp=00000200", busy); end
        req_valid          = 3'b010;
        req_addr[5 +: 5]   = 5'd9;
        rsv_addr           = 5'd12;
        #1;
        vectors++; if (req_ready !== 3'b010) begin errors++; $display("FAIL sb_diff_ready got=%b exp=010", req_ready); end
        tick();
        req_valid = 3'b000;
        rsv_valid = 1'b0;
        vectors++; if (busy !== 32'h1000) begin errors++; $display("FAIL sb_diff got=%h exp=00001000", busy); end
    endtask

    task automatic test_async_reset;
        req_valid          = 3'b001;
        req_addr[0 +: 5]   = 5'd5;
        req_data[0 +: 32]  = 32'h55;
        tick();
        req_valid = 3'b111;
        vectors++; if (wr_en !== 32'h20) begin errors++; $display("FAIL ar_pre_wr_en got=%h exp=00000020", wr_en); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (wr_en !== 32'h0) begin errors++; $display("FAIL ar_wr_en got=%h exp=0", wr_en); end
        vectors++; if (busy !== 32'h0) begin errors++; $display("FAIL ar_busy got=%h exp=0", busy); end
        vectors++; if (req_ready !== 3'b000) begin errors++; $display("FAIL ar_ready got=%b exp=000", req_ready); end
        #1;
        reset = 1'b1;
        #1;
        vectors++; if (req_ready !== 3'b001) begin errors++; $display("FAIL ar_ptr got=%b exp=001", req_ready); end
        tick();
        req_valid = 3'b000;
        vectors++; if (wr_en !== 32'h20) begin errors++; $display("FAIL ar_after got=%h exp=00000020", wr_en); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_writer();
        test_r0_write();
        test_scoreboard();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
